nested_code_encoder: RTL and testbench



---
 rtl/nested_code_pkg.sv | 53 +++++
 rtl/nested_code_encoder_if.sv | 45 ++++
 rtl/nested_code_classify.sv | 14 +
 rtl/nested_code_encoder.sv | 124 ++++++++++++
 tb/tb_nested_code_encoder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/nested_code_pkg.sv
// Shared types, result-code constants and the reference classification function
// used by the nested-compare encoder and its classifier wrapper.
package nested_code_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int CODE_W = 4;
    // Widest operand the shared classify function can take.
    localparam int MAX_W  = 16;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CODE_ALL1      = 4'b1111;
    localparam code_t CODE_B11       = 4'b1000;
    localparam code_t CODE_B11_EVEN  = 4'b0100;
    localparam code_t CODE_B11_NOSUM = 4'b0010;
    localparam code_t CODE_B12       = 4'b0001;
    localparam code_t CODE_B12_A1    = 4'b0011;
    localparam code_t CODE_ZERO      = 4'b0000;

    // Branch order matters: the a != 1 test shadows every later branch, which is
    // why only a handful of codes can ever be produced.
    function automatic code_t classify(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      width
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sum;
        code_t            result;
        mask = (width >= MAX_W) ? {MAX_W{1'b1}} : MAX_W'((32'd1 << width) - 32'd1);
        sum  = (a + b) & mask;
        if (a != MAX_W'(1)) begin
            result = CODE_ALL1;
        end else if (b == MAX_W'(1)) begin
            if (sum == MAX_W'(2)) begin
                result = b[0] ? CODE_B11 : CODE_B11_EVEN;
            end else begin
                result = CODE_B11_NOSUM;
            end
        end else if (b == MAX_W'(2)) begin
            result = a[1] ? CODE_B12_A1 : CODE_B12;
        end else begin
            result = CODE_ZERO;
        end
        return result;
    endfunction

endpackage

// File: rtl/nested_code_encoder_if.sv
// Request/response bundle between a code requester and the nested-code encoder.
interface nested_code_encoder_if #(
    parameter int WIDTH = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_code;
    logic               abort;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_found;
    logic [WIDTH-1:0]   resp_a;
    logic [WIDTH-1:0]   resp_b;
    logic [2*WIDTH:0]   resp_cycles;
    logic               busy;

    modport master (
        output req_valid,
        output req_code,
        output abort,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_found,
        input  resp_a,
        input  resp_b,
        input  resp_cycles,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_code,
        input  abort,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_found,
        output resp_a,
        output resp_b,
        output resp_cycles,
        output busy
    );

endinterface

// File: rtl/nested_code_classify.sv
// Combinational nested-compare classifier: maps operand pair (a,b) to its result code.
module nested_code_classify
    import nested_code_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output code_t            code
);

    assign code = classify(MAX_W'(a), MAX_W'(b), WIDTH);

endmodule

// File: rtl/nested_code_encoder.sv
// Inverse classifier: sweeps candidate (a,b) pairs one per cycle, ascending over
// {a,b}, and reports the first pair whose code equals the requested target.
module nested_code_encoder
    import nested_code_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    nested_code_encoder_if.slave bus
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = IW + 1;
    // Compare width covers both the target port and the fixed-width code.
    localparam int XW = (WIDTH > CODE_W) ? WIDTH : CODE_W;

    state_t            state_reg;
    logic [IW-1:0]     idx_reg;
    logic [WIDTH-1:0]  code_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic              busy_reg;
    logic              resp_found_reg;
    logic [WIDTH-1:0]  resp_a_reg;
    logic [WIDTH-1:0]  resp_b_reg;
    logic [CW-1:0]     resp_cycles_reg;

    logic [WIDTH-1:0]  cand_a;
    logic [WIDTH-1:0]  cand_b;
    code_t             cand_code;
    logic              cand_match;
    logic              idx_last;

    assign cand_a = idx_reg[IW-1:WIDTH];
    assign cand_b = idx_reg[WIDTH-1:0];

    nested_code_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .a    (cand_a),
        .b    (cand_b),
        .code (cand_code)
    );

    assign cand_match = (XW'(cand_code) == XW'(code_reg));
    // End of sweep is the all-ones index; the counter is never allowed to wrap.
    assign idx_last   = &idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            code_reg        <= '0;
            req_ready_reg   <= 1'b1;
            resp_valid_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            resp_found_reg  <= 1'b0;
            resp_a_reg      <= '0;
            resp_b_reg      <= '0;
            resp_cycles_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        code_reg      <= bus.req_code;
                        idx_reg       <= '0;
                        state_reg     <= SEARCH;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                SEARCH: begin
                    // Abort takes priority even over a match found this cycle.
                    if (bus.abort) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end else if (cand_match) begin
                        resp_found_reg  <= 1'b1;
                        resp_a_reg      <= cand_a;
                        resp_b_reg      <= cand_b;
                        resp_cycles_reg <= CW'(idx_reg) + CW'(1);
                        state_reg       <= RESP;
                        busy_reg        <= 1'b0;
                        resp_valid_reg  <= 1'b1;
                    end else if (idx_last) begin
                        resp_found_reg  <= 1'b0;
                        resp_a_reg      <= '0;
                        resp_b_reg      <= '0;
                        resp_cycles_reg <= {1'b1, {IW{1'b0}}};
                        state_reg       <= RESP;
                        busy_reg        <= 1'b0;
                        resp_valid_reg  <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    busy_reg       <= 1'b0;
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.resp_valid  = resp_valid_reg;
    assign bus.busy        = busy_reg;
    assign bus.resp_found  = resp_found_reg;
    assign bus.resp_a      = resp_a_reg;
    assign bus.resp_b      = resp_b_reg;
    assign bus.resp_cycles = resp_cycles_reg;

endmodule

// File: tb/tb_nested_code_encoder.sv
// Bench for nested_code_encoder: a first-match search model drives a per-cycle
// compare, and directed requests pin latencies and results to literal values.
module tb_nested_code_encoder;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    longint cyc = 0;

    int passed = 0;
    int total  = 0;

    nested_code_encoder_if #(.WIDTH(W)) bus ();

    nested_code_encoder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Result code straight from the classification rules.
    function automatic int ref_code(input int a, input int b);
        if (a != 1) return 15;
        if (b == 1) return (((a + b) % (1 << W)) == 2) ? ((b % 2 == 1) ? 8 : 4) : 2;
        if (b == 2) return (((a >> 1) & 1) == 1) ? 3 : 1;
        return 0;
    endfunction

    typedef struct {
        bit found;
        int a;
        int b;
        int cycles;
    } res_t;

    function automatic res_t ref_search(input int target);
        res_t r;
        r.found = 1'b0; r.a = 0; r.b = 0; r.cycles = N;
        for (int i = 0; i < N; i++) begin
            if (ref_code(i >> W, i % (1 << W)) == target) begin
                r.found = 1'b1; r.a = i >> W; r.b = i % (1 << W); r.cycles = i + 1;
                return r;
            end
        end
        return r;
    endfunction

    // Model phases: 0 waiting for request, 1 searching, 2 holding a response.
    int   m_phase = 0;
    int   m_left  = 0;
    bit   m_fresh = 1'b1;
    res_t m_res;

    always @(posedge clk or posedge rst) begin : model
        res_t r;
        if (rst) begin
            m_phase <= 0;
            m_fresh <= 1'b1;
        end else begin
            case (m_phase)
                0: if (bus.req_valid) begin
                    r = ref_search(int'(bus.req_code));
                    m_res   <= r;
                    m_left  <= r.cycles;
                    m_phase <= 1;
                end
                1: if (bus.abort) m_phase <= 0;
                   else if (m_left == 1) begin
                       m_phase <= 2;
                       m_fresh <= 1'b0;
                   end else m_left <= m_left - 1;
                default: if (bus.resp_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("req_ready",  longint'(bus.req_ready),  longint'(m_phase == 0));
        chk("busy",       longint'(bus.busy),       longint'(m_phase == 1));
        chk("resp_valid", longint'(bus.resp_valid), longint'(m_phase == 2));
        if (m_phase == 2) begin
            chk("resp_found",  longint'(bus.resp_found),  longint'(m_res.found));
            chk("resp_a",      longint'(bus.resp_a),      longint'(m_res.a));
            chk("resp_b",      longint'(bus.resp_b),      longint'(m_res.b));
            chk("resp_cycles", longint'(bus.resp_cycles), longint'(m_res.cycles));
        end else if (m_fresh) begin
            chk("reset_found",  longint'(bus.resp_found),  0);
            chk("reset_a",      longint'(bus.resp_a),      0);
            chk("reset_b",      longint'(bus.resp_b),      0);
            chk("reset_cycles", longint'(bus.resp_cycles), 0);
        end
    end

    task automatic send_req(input int code, output longint t0);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_code  = W'(code);
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_req(input int code, input int hold, input bit poke,
                          input int f, input int a, input int b, input int c, input int lat);
        longint t0;
        int n;
        send_req(code, t0);
        n = 0;
        while (!bus.resp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) begin
            chk($sformatf("timeout_%0d", code), 0, 1);
            return;
        end
        chk($sformatf("latency_%0d", code), cyc - t0, lat);
        chk($sformatf("found_%0d", code),  longint'(bus.resp_found),  f);
        chk($sformatf("a_%0d", code),      longint'(bus.resp_a),      a);
        chk($sformatf("b_%0d", code),      longint'(bus.resp_b),      b);
        chk($sformatf("cycles_%0d", code), longint'(bus.resp_cycles), c);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            bus.req_valid = poke && (h == 2);
            bus.abort     = poke && (h == 2);
            bus.req_code  = '0;
        end
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        if (hold > 0) begin
            chk("hold_valid",  longint'(bus.resp_valid),  1);
            chk("hold_ready",  longint'(bus.req_ready),   0);
            chk("hold_cycles", longint'(bus.resp_cycles), c);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("after_ack_ready", longint'(bus.req_ready), 1);
    endtask

    initial begin
        longint t0;
        res_t r;
        bus.req_valid  = 1'b0;
        bus.req_code   = '0;
        bus.abort      = 1'b0;
        bus.resp_ready = 1'b0;

        r = ref_search(8);
        chk("model_1000_cycles", longint'(r.cycles), 18);
        r = ref_search(4);
        chk("model_0100_found", longint'(r.found), 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready", longint'(bus.req_ready), 1);

        do_req(15, 0, 1'b0, 1, 0, 0, 1,   2);
        do_req(8,  0, 1'b0, 1, 1, 1, 18,  19);
        do_req(1,  0, 1'b0, 1, 1, 2, 19,  20);
        do_req(0,  0, 1'b0, 1, 1, 0, 17,  18);
        do_req(4,  0, 1'b0, 0, 0, 0, 256, 257);
        // Held response with a request and an abort poked during RESP.
        do_req(8,  5, 1'b1, 1, 1, 1, 18,  19);

        // Abort mid-sweep in cycle 50.
        send_req(4, t0);
        repeat (49) begin @(posedge clk); #1; end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_idle_ready", longint'(bus.req_ready), 1);
        chk("abort_idle_busy",  longint'(bus.busy),      0);
        repeat (260) @(posedge clk);
        #1;

        // Abort in the very cycle that would match.
        send_req(15, t0);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_match_valid", longint'(bus.resp_valid), 0);
        chk("abort_match_ready", longint'(bus.req_ready),  1);
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset mid-search.
        send_req(4, t0);
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rst_req_ready",   longint'(bus.req_ready),   1);
        chk("rst_busy",        longint'(bus.busy),        0);
        chk("rst_resp_valid",  longint'(bus.resp_valid),  0);
        chk("rst_resp_cycles", longint'(bus.resp_cycles), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_req(1, 0, 1'b0, 1, 1, 2, 19, 20);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
